// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1 or 2 stop bits.
// The 2-flop synchronized line drives every decision; results are registered on the final stop sample.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int IDX_W   = $clog2(IDX_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID        = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST  = IDX_W'(STOP_BITS - 1);
  localparam logic             ODD_PAR        = (PARITY == 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_rx_meta, r_rx_s;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx, w_idx_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_perr, w_perr_nxt;
  logic                   r_ferr, w_ferr_nxt;
  logic                   r_armed, w_armed_nxt;
  logic                   w_tick, w_done, w_par_bad;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_par_bad = ((^r_shift) ^ r_rx_s) != ODD_PAR;
  assign busy      = (r_state != StIdle);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_perr_nxt  = r_perr;
    w_ferr_nxt  = r_ferr;
    w_armed_nxt = r_armed;
    w_done      = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        // After a break the line must be seen high before a new start is taken.
        if (r_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt = StStart;
          w_perr_nxt  = 1'b0;
          w_ferr_nxt  = 1'b0;
        end
      end
      StStart: begin
        if (r_cnt == CNT_MID) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rx_s ? StIdle : StData;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StData: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_DATA_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = (PARITY != 0) ? StPar : StStop;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StPar: begin
        if (w_tick) begin
          w_cnt_nxt   = '0;
          w_perr_nxt  = w_par_bad;
          w_state_nxt = StStop;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StStop: begin
        if (w_tick) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) w_ferr_nxt = 1'b1;
          if (r_idx == IDX_STOP_LAST) begin
            w_idx_nxt   = '0;
            w_state_nxt = StIdle;
            w_armed_nxt = r_rx_s;
            w_done      = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta  <= 1'b1;
      r_rx_s     <= 1'b1;
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_armed    <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_perr    <= w_perr_nxt;
      r_ferr    <= w_ferr_nxt;
      r_armed   <= w_armed_nxt;
      valid_out <= w_done;
      if (w_done) begin
        data_out   <= r_shift;
        parity_err <= w_perr_nxt;
        frame_err  <= w_ferr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit, driven with
// directed and random frames; a reference model queues expected words, monitors pop on valid_out.
module tb_uart_rx_cfg;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rx;
  logic [7:0] d_a, d_c;
  logic [6:0] d_b;
  logic [2:0] v, pe, fe, bz;
  logic [2:0] pv = '0;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx(rx[0]), .data_out(d_a), .valid_out(v[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .busy(bz[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx(rx[1]), .data_out(d_b), .valid_out(v[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .busy(bz[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rx(rx[2]), .data_out(d_c), .valid_out(v[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .busy(bz[2]));

  typedef struct {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    int unsigned t0;
    int unsigned nb;
  } exp_t;

  exp_t        q_a[$], q_b[$], q_c[$];
  int unsigned vt_a[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dbits(input int ch);
    return (ch == 1) ? 7 : 8;
  endfunction
  function automatic int pbits(input int ch);
    return (ch == 1) ? 1 : 0;
  endfunction
  function automatic int sbits(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction
  function automatic int flen(input int ch);
    return 1 + dbits(ch) + pbits(ch) + sbits(ch);
  endfunction

  // Line bits in transmit order (bit 0 = start); stop_v[s] is the level of stop bit s.
  function automatic logic [15:0] mk(input int ch, input logic [8:0] data, input bit bad_par,
                                     input logic [1:0] stop_v);
    logic [15:0] b;
    int ones;
    b = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < dbits(ch); i++) begin
      b[1+i] = data[i];
      ones += int'(data[i]);
    end
    if (pbits(ch) == 1) b[1+dbits(ch)] = ((ones % 2) == 1) ^ bad_par;
    for (int s = 0; s < sbits(ch); s++) b[1+dbits(ch)+pbits(ch)+s] = stop_v[s];
    return b;
  endfunction

  // Reference model: decode what a receiver must report for a given line frame.
  function automatic exp_t model(input int ch, input logic [15:0] b);
    exp_t e;
    int ones;
    e.data = '0;
    e.perr = 1'b0;
    e.ferr = 1'b0;
    e.t0   = 0;
    e.nb   = flen(ch);
    ones   = 0;
    for (int i = 0; i < dbits(ch); i++) e.data[i] = b[1+i];
    ones = $countones(e.data);
    if (pbits(ch) == 1) e.perr = ((ones + int'(b[1+dbits(ch)])) % 2) != 0;  // even parity
    for (int s = 0; s < sbits(ch); s++)
      if (b[1+dbits(ch)+pbits(ch)+s] == 1'b0) e.ferr = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Starts and ends at posedge+1, so consecutive calls produce zero idle gap.
  task automatic send(input int ch, input logic [15:0] b, input bit push);
    exp_t e;
    if (push) begin
      e = model(ch, b);
      e.t0 = cyc;
      case (ch)
        0: q_a.push_back(e);
        1: q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
    for (int k = 0; k < flen(ch); k++) begin
      rx[ch] = b[k];
      idle(CPB);
    end
    rx[ch] = 1'b1;
  endtask

  task automatic mon_pop(input int ch, input logic [8:0] d, input logic p, input logic f,
                         input logic prev_v);
    exp_t e;
    bit got;
    int unsigned lat;
    got = 1'b0;
    case (ch)
      0: if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1'b1; end
    endcase
    check($sformatf("ch%0d single_cycle_valid", ch), {31'd0, prev_v}, 32'd0);
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL ch%0d unexpected_valid: got data 0x%0h, required no valid_out", ch, d);
    end else begin
      check($sformatf("ch%0d data", ch), {23'd0, d}, {23'd0, e.data});
      check($sformatf("ch%0d parity_err", ch), {31'd0, p}, {31'd0, e.perr});
      check($sformatf("ch%0d frame_err", ch), {31'd0, f}, {31'd0, e.ferr});
      // Final stop bit is sampled mid-bit, plus synchronizer delay.
      lat = cyc - e.t0;
      n_tests++;
      if (lat < (e.nb - 1) * CPB + 4 || lat > e.nb * CPB) begin
        n_fail++;
        $display("FAIL ch%0d valid_latency: got %0d cycles, required %0d..%0d", ch, lat,
                 (e.nb - 1) * CPB + 4, e.nb * CPB);
      end
    end
    if (ch == 0) vt_a.push_back(cyc);
  endtask

  always @(negedge clk) if (rst_n && v[0]) mon_pop(0, {1'b0, d_a}, pe[0], fe[0], pv[0]);
  always @(negedge clk) if (rst_n && v[1]) mon_pop(1, {2'b0, d_b}, pe[1], fe[1], pv[1]);
  always @(negedge clk) if (rst_n && v[2]) mon_pop(2, {1'b0, d_c}, pe[2], fe[2], pv[2]);
  always @(negedge clk) pv <= v;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required $finish first");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    logic [8:0] data;
    bit badp;
    logic [1:0] sv;
    logic [15:0] b;

    rst_n = 1'b0;
    rx    = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset ch%0d valid", i), {31'd0, v[i]}, 32'd0);
      check($sformatf("reset ch%0d busy", i), {31'd0, bz[i]}, 32'd0);
      check($sformatf("reset ch%0d perr", i), {31'd0, pe[i]}, 32'd0);
      check($sformatf("reset ch%0d ferr", i), {31'd0, fe[i]}, 32'd0);
    end
    check("reset data a", {24'd0, d_a}, 32'd0);
    check("reset data b", {25'd0, d_b}, 32'd0);
    check("reset data c", {24'd0, d_c}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);

    // 8N1 basic frame
    send(0, mk(0, 9'hA5, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("8N1 A5 data hold", {24'd0, d_a}, 32'hA5);
    check("8N1 A5 busy after", {31'd0, bz[0]}, 32'd0);

    // 7E1 wrong then right parity
    send(1, mk(1, 9'h41, 1'b1, 2'b11), 1'b1);
    idle(20);
    check("7E1 41 bad parity flag", {31'd0, pe[1]}, 32'd1);
    send(1, mk(1, 9'h41, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("7E1 41 good parity flag", {31'd0, pe[1]}, 32'd0);
    check("7E1 41 data", {25'd0, d_b}, 32'h41);

    // 8N2 second stop low, then clean frame
    send(2, mk(2, 9'h3C, 1'b0, 2'b01), 1'b1);
    idle(CPB);
    check("8N2 3C frame_err", {31'd0, fe[2]}, 32'd1);
    check("8N2 3C data", {24'd0, d_c}, 32'h3C);
    send(2, mk(2, 9'h55, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("8N2 55 frame_err", {31'd0, fe[2]}, 32'd0);

    // Short glitch is rejected at mid start bit
    rx[0] = 1'b0;
    idle(4);
    check("glitch busy high", {31'd0, bz[0]}, 32'd1);
    rx[0] = 1'b1;
    idle(CPB);
    check("glitch back to idle", {31'd0, bz[0]}, 32'd0);

    // Reset in the middle of data bit 3
    b = mk(0, 9'hFF, 1'b0, 2'b11);
    for (int k = 0; k < 4; k++) begin
      rx[0] = b[k];
      idle(CPB);
    end
    rx[0] = b[4];
    idle(CPB / 2);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    rx[0] = 1'b1;
    check("mid-frame reset data", {24'd0, d_a}, 32'd0);
    check("mid-frame reset busy", {31'd0, bz[0]}, 32'd0);
    idle(200);
    send(0, mk(0, 9'h12, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("after reset 12 data", {24'd0, d_a}, 32'h12);

    // Back-to-back frames, zero idle gap
    vt_a.delete();
    send(0, mk(0, 9'h00, 1'b0, 2'b11), 1'b1);
    send(0, mk(0, 9'hFF, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("b2b pulse count", vt_a.size(), 32'd2);
    if (vt_a.size() == 2) check("b2b pulse spacing", vt_a[1] - vt_a[0], 32'd160);

    // Break: line held low past the stop bit, then released
    send(0, mk(0, 9'h00, 1'b0, 2'b00), 1'b1);
    rx[0] = 1'b0;
    idle(3 * CPB);
    check("break frame_err", {31'd0, fe[0]}, 32'd1);
    check("break no restart while low", {31'd0, bz[0]}, 32'd0);
    rx[0] = 1'b1;
    idle(CPB);
    send(0, mk(0, 9'h5A, 1'b0, 2'b11), 1'b1);
    idle(20);
    check("after break frame_err", {31'd0, fe[0]}, 32'd0);

    // Random frames across all configurations
    for (int n = 0; n < 60; n++) begin
      ch   = int'($urandom_range(0, 2));
      data = 9'($urandom);
      badp = ($urandom_range(0, 3) == 0);
      sv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send(ch, mk(ch, data, badp, sv), 1'b1);
      if (sv != 2'b11) idle(CPB + int'($urandom_range(0, 5)));
      else if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)));
    end

    idle(300);
    check("queue a drained", q_a.size(), 32'd0);
    check("queue b drained", q_b.size(), 32'd0);
    check("queue c drained", q_c.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
